// File: rtl/osd_dem_uart_16550_pkg.sv
// Shared constants for the 16550-compatible register front end of the UART debug module.
// Holds the register offsets, IIR codes, LSR/FCR/IER bit positions and the IIR priority encoder.
package osd_uart16550_pkg;

   localparam logic [2:0] REG_RBR_THR = 3'd0;
   localparam logic [2:0] REG_IER     = 3'd1;
   localparam logic [2:0] REG_IIR_FCR = 3'd2;
   localparam logic [2:0] REG_LCR     = 3'd3;
   localparam logic [2:0] REG_MCR     = 3'd4;
   localparam logic [2:0] REG_LSR     = 3'd5;
   localparam logic [2:0] REG_MSR     = 3'd6;
   localparam logic [2:0] REG_SCR     = 3'd7;

   localparam logic [7:0] IIR_NONE = 8'hC1;
   localparam logic [7:0] IIR_THRE = 8'hC2;
   localparam logic [7:0] IIR_RDA  = 8'hC4;

   localparam int LSR_DR   = 0;
   localparam int LSR_THRE = 5;
   localparam int LSR_TEMT = 6;

   localparam int FCR_RX_CLR = 1;
   localparam int FCR_TX_CLR = 2;

   localparam int IER_RDA  = 0;
   localparam int IER_THRE = 1;

   localparam int LCR_DLAB = 7;

   // Received data outranks THR-empty, as on a real 16550.
   function automatic logic [7:0] iirEncode(input logic rdaPending, input logic threPending);
      logic [7:0] code;
      code = IIR_NONE;
      if (rdaPending) begin
         code = IIR_RDA;
      end else if (threPending) begin
         code = IIR_THRE;
      end
      return code;
   endfunction

endpackage

// File: rtl/osd_dem_uart_16550_if.sv
// CPU-side Wishbone-style register bus of the 16550 front end.
// The CPU drives the master side; the register block is the slave.
interface osd_dem_uart_16550_if;

   logic [2:0] wb_adr_i;
   logic [7:0] wb_dat_i;
   logic       wb_we_i;
   logic       wb_cyc_i;
   logic       wb_stb_i;
   logic [7:0] wb_dat_o;
   logic       wb_ack_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o
   );

endinterface

// File: rtl/osd_dem_uart_16550_fifo.sv
// Synchronous character FIFO with show-ahead output; clear beats push, and a push
// into a full FIFO is only taken when a pop frees a slot in the same cycle.
module osd_uart16550_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic             doPop, doPush;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty  = (wrPtr_q == rdPtr_q);
   assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign doPop  = pop & ~empty;
   assign doPush = push & (~full | doPop);
   assign dout   = mem_q[rdPtr_q[AW-1:0]];

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (clear) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
         if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush && !clear) begin
         mem_q[wrPtr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/osd_dem_uart_16550.sv
// 16550-compatible register front end: THR characters go out to the debug module,
// host characters come back through RBR, with LSR status and a level interrupt.
module osd_dem_uart_16550
   import osd_uart16550_pkg::*;
#(
   parameter int TX_FIFO_DEPTH = 16,
   parameter int RX_FIFO_DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   osd_dem_uart_16550_if.slave     wb,
   output logic                    irq,
   output logic [7:0]              out_char,
   output logic                    out_valid,
   input  logic                    out_ready,
   input  logic [7:0]              in_char,
   input  logic                    in_valid,
   output logic                    in_ready
);

   logic       ack_q, ack_d;
   logic [7:0] dat_q, dat_d;
   logic [1:0] ier_q, ier_d;
   logic [7:0] lcr_q, lcr_d;
   logic [4:0] mcr_q, mcr_d;
   logic [7:0] scr_q, scr_d;
   logic [7:0] dll_q, dll_d;
   logic [7:0] dlm_q, dlm_d;
   logic       threIp_q, threIp_d;
   logic       txEmptyPrev_q;
   logic       irq_q, irq_d;

   logic       req, wrReq, rdReq, dlab;
   logic       txPush, txPop, txClear, txFull, txEmpty, thrAccepted;
   logic       rxPush, rxPop, rxClear, rxFull, rxEmpty;
   logic [7:0] txDout, rxDout;
   logic [7:0] iirVal, lsrVal, rdData;

   // An access is taken once, in the cycle before its ack.
   assign req   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
   assign wrReq = req & wb.wb_we_i;
   assign rdReq = req & ~wb.wb_we_i;
   assign dlab  = lcr_q[LCR_DLAB];

   assign txPush      = wrReq & (wb.wb_adr_i == REG_RBR_THR) & ~dlab;
   assign txPop       = out_valid & out_ready;
   assign txClear     = wrReq & (wb.wb_adr_i == REG_IIR_FCR) & wb.wb_dat_i[FCR_TX_CLR];
   assign thrAccepted = txPush & (~txFull | txPop);

   assign rxPush  = in_valid & in_ready;
   assign rxPop   = rdReq & (wb.wb_adr_i == REG_RBR_THR) & ~dlab;
   assign rxClear = wrReq & (wb.wb_adr_i == REG_IIR_FCR) & wb.wb_dat_i[FCR_RX_CLR];

   osd_uart16550_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_txFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (txPush),
      .pop   (txPop),
      .clear (txClear),
      .din   (wb.wb_dat_i),
      .dout  (txDout),
      .full  (txFull),
      .empty (txEmpty)
   );

   osd_uart16550_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rxFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rxPush),
      .pop   (rxPop),
      .clear (rxClear),
      .din   (in_char),
      .dout  (rxDout),
      .full  (rxFull),
      .empty (rxEmpty)
   );

   assign out_valid = ~txEmpty;
   assign out_char  = txDout;
   assign in_ready  = ~rxFull;
   assign irq       = irq_q;
   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;

   assign iirVal = iirEncode(ier_q[IER_RDA] & ~rxEmpty, ier_q[IER_THRE] & threIp_q);

   always_comb begin
      lsrVal           = 8'h00;
      lsrVal[LSR_DR]   = ~rxEmpty;
      lsrVal[LSR_THRE] = txEmpty;
      lsrVal[LSR_TEMT] = txEmpty & ~out_valid;
   end

   always_comb begin
      rdData = 8'h00;
      case (wb.wb_adr_i)
         REG_RBR_THR: rdData = dlab ? dll_q : (rxEmpty ? 8'h00 : rxDout);
         REG_IER:     rdData = dlab ? dlm_q : {6'b0, ier_q};
         REG_IIR_FCR: rdData = iirVal;
         REG_LCR:     rdData = lcr_q;
         REG_MCR:     rdData = {3'b0, mcr_q};
         REG_LSR:     rdData = lsrVal;
         REG_MSR:     rdData = 8'h00;
         REG_SCR:     rdData = scr_q;
         default:     rdData = 8'h00;
      endcase
   end

   always_comb begin
      ier_d = ier_q;
      lcr_d = lcr_q;
      mcr_d = mcr_q;
      scr_d = scr_q;
      dll_d = dll_q;
      dlm_d = dlm_q;
      if (wrReq) begin
         case (wb.wb_adr_i)
            REG_RBR_THR: if (dlab) dll_d = wb.wb_dat_i;
            REG_IER:     if (dlab) dlm_d = wb.wb_dat_i; else ier_d = wb.wb_dat_i[1:0];
            REG_LCR:     lcr_d = wb.wb_dat_i;
            REG_MCR:     mcr_d = wb.wb_dat_i[4:0];
            REG_SCR:     scr_d = wb.wb_dat_i;
            default:     ;
         endcase
      end
   end

   // THRE pending: set when TX drains or THRE gets enabled on an empty TX; clears take priority.
   always_comb begin
      threIp_d = threIp_q;
      if (txEmpty && !txEmptyPrev_q) begin
         threIp_d = 1'b1;
      end
      if (wrReq && (wb.wb_adr_i == REG_IER) && !dlab &&
          wb.wb_dat_i[IER_THRE] && !ier_q[IER_THRE] && txEmpty) begin
         threIp_d = 1'b1;
      end
      if (thrAccepted) begin
         threIp_d = 1'b0;
      end
      if (rdReq && (wb.wb_adr_i == REG_IIR_FCR) && (iirVal == IIR_THRE)) begin
         threIp_d = 1'b0;
      end
   end

   assign irq_d = (ier_q[IER_RDA] & ~rxEmpty) | (ier_q[IER_THRE] & threIp_q);
   assign ack_d = req;
   assign dat_d = rdReq ? rdData : dat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q         <= 1'b0;
         dat_q         <= 8'h00;
         ier_q         <= 2'b00;
         lcr_q         <= 8'h03;
         mcr_q         <= 5'h00;
         scr_q         <= 8'h00;
         dll_q         <= 8'h00;
         dlm_q         <= 8'h00;
         threIp_q      <= 1'b0;
         txEmptyPrev_q <= 1'b1;
         irq_q         <= 1'b0;
      end else begin
         ack_q         <= ack_d;
         dat_q         <= dat_d;
         ier_q         <= ier_d;
         lcr_q         <= lcr_d;
         mcr_q         <= mcr_d;
         scr_q         <= scr_d;
         dll_q         <= dll_d;
         dlm_q         <= dlm_d;
         threIp_q      <= threIp_d;
         txEmptyPrev_q <= txEmpty;
         irq_q         <= irq_d;
      end
   end

endmodule

// File: tb/tb_osd_dem_uart_16550.sv
// Directed bench for the 16550 front end: a register-access vector table plus
// hand-written sequences for TX/RX flow, interrupts, FIFO clears and reset.
module tb_osd_dem_uart_16550;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       irq;
   logic [7:0] out_char;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] in_char = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;

   int nCompared   = 0;
   int nMismatched = 0;

   osd_dem_uart_16550_if bus();

   osd_dem_uart_16550 #(.TX_FIFO_DEPTH(16), .RX_FIFO_DEPTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .wb        (bus),
      .irq       (irq),
      .out_char  (out_char),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .in_char   (in_char),
      .in_valid  (in_valid),
      .in_ready  (in_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       write;
      logic [2:0] adr;
      logic [7:0] dat;
      logic [7:0] expRd;
   } vec_t;

   vec_t vecs[21];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One bus access starting at a negedge; returns at a negedge after one idle cycle.
   task automatic applyStimulus(input logic write, input logic [2:0] adr, input logic [7:0] dat,
                                output logic [7:0] rd);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = write;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = dat;
      @(posedge clk);
      @(negedge clk);
      checkOutput("ack", {31'b0, bus.wb_ack_o}, 32'd1);
      rd = bus.wb_dat_o;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("ackWidth", {31'b0, bus.wb_ack_o}, 32'd0);
   endtask

   task automatic busWrite(input logic [2:0] adr, input logic [7:0] dat);
      logic [7:0] unused;
      applyStimulus(1'b1, adr, dat, unused);
   endtask

   task automatic busRead(input string name, input logic [2:0] adr, input logic [7:0] expected);
      logic [7:0] rd;
      applyStimulus(1'b0, adr, 8'h00, rd);
      checkOutput(name, {24'b0, rd}, {24'b0, expected});
   endtask

   initial begin
      logic [7:0] rd;
      int got;
      int pushed;

      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = 3'd0;
      bus.wb_dat_i = 8'h00;

      vecs[0]  = '{1'b0, 3'd2, 8'h00, 8'hC1};
      vecs[1]  = '{1'b0, 3'd3, 8'h00, 8'h03};
      vecs[2]  = '{1'b0, 3'd5, 8'h00, 8'h60};
      vecs[3]  = '{1'b0, 3'd6, 8'h00, 8'h00};
      vecs[4]  = '{1'b0, 3'd1, 8'h00, 8'h00};
      vecs[5]  = '{1'b1, 3'd7, 8'hA5, 8'h00};
      vecs[6]  = '{1'b0, 3'd7, 8'h00, 8'hA5};
      vecs[7]  = '{1'b1, 3'd4, 8'hFF, 8'h00};
      vecs[8]  = '{1'b0, 3'd4, 8'h00, 8'h1F};
      vecs[9]  = '{1'b1, 3'd3, 8'h83, 8'h00};
      vecs[10] = '{1'b1, 3'd0, 8'h34, 8'h00};
      vecs[11] = '{1'b1, 3'd1, 8'h12, 8'h00};
      vecs[12] = '{1'b0, 3'd0, 8'h00, 8'h34};
      vecs[13] = '{1'b0, 3'd1, 8'h00, 8'h12};
      vecs[14] = '{1'b0, 3'd5, 8'h00, 8'h60};
      vecs[15] = '{1'b1, 3'd3, 8'h03, 8'h00};
      vecs[16] = '{1'b0, 3'd3, 8'h00, 8'h03};
      vecs[17] = '{1'b0, 3'd1, 8'h00, 8'h00};
      vecs[18] = '{1'b0, 3'd0, 8'h00, 8'h00};
      vecs[19] = '{1'b1, 3'd5, 8'hFF, 8'h00};
      vecs[20] = '{1'b0, 3'd5, 8'h00, 8'h60};

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstAck", {31'b0, bus.wb_ack_o}, 32'd0);
      checkOutput("rstDat", {24'b0, bus.wb_dat_o}, 32'd0);
      checkOutput("rstIrq", {31'b0, irq}, 32'd0);
      checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
      checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] register vector table");
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].write, vecs[i].adr, vecs[i].dat, rd);
         if (!vecs[i].write) begin
            checkOutput($sformatf("vec%0d", i), {24'b0, rd}, {24'b0, vecs[i].expRd});
         end
      end

      $display("[TB] TX two characters");
      busWrite(3'd0, 8'h41);
      busWrite(3'd0, 8'h42);
      checkOutput("txValid", {31'b0, out_valid}, 32'd1);
      checkOutput("txHead0", {24'b0, out_char}, 32'h41);
      busRead("lsrBusy", 3'd5, 8'h00);
      out_ready = 1'b1;
      checkOutput("txChar0", {24'b0, out_char}, 32'h41);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("txChar1", {24'b0, out_char}, 32'h42);
      checkOutput("txValid1", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("txDrained", {31'b0, out_valid}, 32'd0);
      busRead("lsrIdle", 3'd5, 8'h60);

      $display("[TB] RX character with RDA interrupt");
      busWrite(3'd1, 8'h01);
      checkOutput("irqQuiet", {31'b0, irq}, 32'd0);
      in_char  = 8'h5A;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("irqRxLat1", {31'b0, irq}, 32'd0);
      @(negedge clk);
      checkOutput("irqRxLat2", {31'b0, irq}, 32'd1);
      busRead("iirRda", 3'd2, 8'hC4);
      busRead("rbr5A", 3'd0, 8'h5A);
      checkOutput("irqRxClr", {31'b0, irq}, 32'd0);
      busRead("lsrRxEmpty", 3'd5, 8'h60);
      busWrite(3'd1, 8'h00);

      $display("[TB] TX overflow");
      for (int i = 0; i < 17; i++) begin
         busWrite(3'd0, 8'(i));
      end
      busRead("lsrFull", 3'd5, 8'h00);
      got = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 24; c++) begin
         if (out_valid) begin
            checkOutput($sformatf("drain%0d", got), {24'b0, out_char}, got);
            got++;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      checkOutput("drainCount", got, 32'd16);

      $display("[TB] THRE interrupt");
      busWrite(3'd1, 8'h02);
      checkOutput("irqThre", {31'b0, irq}, 32'd1);
      busRead("iirThre", 3'd2, 8'hC2);
      checkOutput("irqThreClr", {31'b0, irq}, 32'd0);
      busRead("iirNone", 3'd2, 8'hC1);
      busWrite(3'd1, 8'h00);
      busWrite(3'd1, 8'h02);
      checkOutput("irqIerRise", {31'b0, irq}, 32'd1);
      busWrite(3'd0, 8'h77);
      checkOutput("irqThrClr", {31'b0, irq}, 32'd0);
      checkOutput("thrValid", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("irqThreAgain", {31'b0, irq}, 32'd1);
      busRead("iirThre2", 3'd2, 8'hC2);
      busWrite(3'd1, 8'h00);

      $display("[TB] RX fill and FCR clear");
      pushed = 0;
      for (int c = 0; c < 24; c++) begin
         if (in_ready) begin
            in_char  = 8'(8'h80 + pushed);
            in_valid = 1'b1;
            pushed++;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checkOutput("rxPushed", pushed, 32'd16);
      checkOutput("rxFullReady", {31'b0, in_ready}, 32'd0);
      busRead("lsrRxFull", 3'd5, 8'h61);
      busRead("rbr80", 3'd0, 8'h80);
      busRead("rbr81", 3'd0, 8'h81);
      checkOutput("rxReadyAgain", {31'b0, in_ready}, 32'd1);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b1;
      bus.wb_adr_i = 3'd2;
      bus.wb_dat_i = 8'h02;
      in_char  = 8'hEE;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("fcrAck", {31'b0, bus.wb_ack_o}, 32'd1);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      checkOutput("fcrInReady", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      busRead("lsrRxCleared", 3'd5, 8'h60);
      busRead("rbrCleared", 3'd0, 8'h00);

      $display("[TB] TX clear and reset mid-transfer");
      busWrite(3'd0, 8'h11);
      busWrite(3'd0, 8'h22);
      busWrite(3'd2, 8'h04);
      checkOutput("txClrValid", {31'b0, out_valid}, 32'd0);
      busRead("lsrTxClr", 3'd5, 8'h60);
      busWrite(3'd0, 8'h33);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = 3'd5;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstDropAck", {31'b0, bus.wb_ack_o}, 32'd0);
      checkOutput("rstFlushTx", {31'b0, out_valid}, 32'd0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postRstValid", {31'b0, out_valid}, 32'd0);
      checkOutput("postRstReady", {31'b0, in_ready}, 32'd1);
      busRead("postRstScr", 3'd7, 8'h00);
      busRead("postRstLcr", 3'd3, 8'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
